// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with two completion ports and two decode lookup ports.
// Optional macro ROB_FORWARD_EN forwards same-cycle completions into the lookup results.
module reorder_buffer #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32,
    parameter int ID_SIZE          = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ROB_alloc,
    input  logic [REG_ADDRESS_SIZE-1:0] ROB_alloc_dest,
    input  logic                        ROB_alloc_w,
    output logic [ID_SIZE-1:0]          ROB_tail,
    output logic                        ROB_stall,
    input  logic                        ROB_cmp0,
    input  logic [ID_SIZE-1:0]          ROB_cmp0_id,
    input  logic [REG_SIZE-1:0]         ROB_cmp0_value,
    input  logic                        ROB_cmp1,
    input  logic [ID_SIZE-1:0]          ROB_cmp1_id,
    input  logic [REG_SIZE-1:0]         ROB_cmp1_value,
    input  logic [REG_ADDRESS_SIZE-1:0] ROB_dAddr1,
    input  logic [REG_ADDRESS_SIZE-1:0] ROB_dAddr2,
    output logic                        ROB_dependency1,
    output logic                        ROB_dependency2,
    output logic                        ROB_resolved1,
    output logic                        ROB_resolved2,
    output logic [REG_SIZE-1:0]         ROB_dValue1,
    output logic [REG_SIZE-1:0]         ROB_dValue2,
    output logic [REG_ADDRESS_SIZE-1:0] ROB_Wat,
    output logic [REG_SIZE-1:0]         ROB_Wvalue,
    output logic                        ROB_We,
    input  logic                        ROB_flush
);

    localparam int DEPTH = 2 ** ID_SIZE;
    localparam logic [ID_SIZE:0] FULL_COUNT = (ID_SIZE + 1)'(DEPTH);

    logic [ID_SIZE-1:0] head_reg;
    logic [ID_SIZE-1:0] tail_reg;
    logic [ID_SIZE:0]   count_reg;

    logic [DEPTH-1:0]            valid_vec;
    logic [DEPTH-1:0]            done_vec;
    logic [DEPTH-1:0]            w_vec;
    logic [REG_ADDRESS_SIZE-1:0] dest_vec  [DEPTH];
    logic [REG_SIZE-1:0]         value_vec [DEPTH];

    logic alloc_ok;
    logic commit;

    assign ROB_stall = (count_reg == FULL_COUNT);
    assign ROB_tail  = tail_reg;
    assign alloc_ok  = ROB_alloc && !ROB_stall && !ROB_flush;
    assign commit    = valid_vec[head_reg] && done_vec[head_reg];

    assign ROB_We     = commit && w_vec[head_reg] && (dest_vec[head_reg] != '0);
    assign ROB_Wat    = commit ? dest_vec[head_reg] : '0;
    assign ROB_Wvalue = commit ? value_vec[head_reg] : '0;

    // A flush collapses the buffer onto the slot just past the (possibly committing) head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (commit)
                head_reg <= head_reg + ID_SIZE'(1);
            if (ROB_flush) begin
                tail_reg  <= head_reg + ID_SIZE'(commit);
                count_reg <= '0;
            end else begin
                if (alloc_ok)
                    tail_reg <= tail_reg + ID_SIZE'(1);
                count_reg <= count_reg + (ID_SIZE + 1)'(alloc_ok) - (ID_SIZE + 1)'(commit);
            end
        end
    end

    genvar gi, gp;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [ID_SIZE-1:0] ENTRY_ID = ID_SIZE'(gi);
            logic                        valid_reg;
            logic                        done_reg;
            logic                        w_reg;
            logic [REG_ADDRESS_SIZE-1:0] dest_reg;
            logic [REG_SIZE-1:0]         value_reg;
            logic                        hit0;
            logic                        hit1;

            assign hit0 = ROB_cmp0 && (ROB_cmp0_id == ENTRY_ID) && valid_reg;
            assign hit1 = ROB_cmp1 && (ROB_cmp1_id == ENTRY_ID) && valid_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                    w_reg     <= 1'b0;
                    dest_reg  <= '0;
                    value_reg <= '0;
                end else if (ROB_flush || (commit && head_reg == ENTRY_ID)) begin
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (alloc_ok && tail_reg == ENTRY_ID) begin
                    valid_reg <= 1'b1;
                    done_reg  <= 1'b0;
                    w_reg     <= ROB_alloc_w;
                    dest_reg  <= ROB_alloc_dest;
                    value_reg <= '0;
                end else if (hit0) begin
                    done_reg  <= 1'b1;
                    value_reg <= ROB_cmp0_value;
                end else if (hit1) begin
                    done_reg  <= 1'b1;
                    value_reg <= ROB_cmp1_value;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign done_vec[gi]  = done_reg;
            assign w_vec[gi]     = w_reg;
            assign dest_vec[gi]  = dest_reg;
            assign value_vec[gi] = value_reg;
        end
    endgenerate

    logic [REG_ADDRESS_SIZE-1:0] query_addr [2];
    assign query_addr[0] = ROB_dAddr1;
    assign query_addr[1] = ROB_dAddr2;

    generate
        for (gp = 0; gp < 2; gp++) begin : g_port
            logic [DEPTH-1:0]   match;
            logic               found;
            logic [ID_SIZE-1:0] sel;
            logic               dep;
            logic               res;
            logic [REG_SIZE-1:0] val;

            for (gi = 0; gi < DEPTH; gi++) begin : g_match
                assign match[gi] = valid_vec[gi] && w_vec[gi] && (query_addr[gp] != '0)
                                   && (dest_vec[gi] == query_addr[gp]);
            end

            // Walk oldest to youngest from head so the last hit is the youngest producer.
            always_comb begin
                found = 1'b0;
                sel   = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[head_reg + ID_SIZE'(i)]) begin
                        found = 1'b1;
                        sel   = head_reg + ID_SIZE'(i);
                    end
                end
            end

            always_comb begin
                dep = found;
                res = found && done_vec[sel];
                val = found ? value_vec[sel] : '0;
`ifdef ROB_FORWARD_EN
                if (found && ROB_cmp0 && ROB_cmp0_id == sel) begin
                    res = 1'b1;
                    val = ROB_cmp0_value;
                end else if (found && ROB_cmp1 && ROB_cmp1_id == sel) begin
                    res = 1'b1;
                    val = ROB_cmp1_value;
                end
`else
`endif
            end
        end
    endgenerate

    assign ROB_dependency1 = g_port[0].dep;
    assign ROB_resolved1   = g_port[0].res;
    assign ROB_dValue1     = g_port[0].val;
    assign ROB_dependency2 = g_port[1].dep;
    assign ROB_resolved2   = g_port[1].res;
    assign ROB_dValue2     = g_port[1].val;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ROB_alloc;
    logic [4:0]  ROB_alloc_dest;
    logic        ROB_alloc_w;
    logic [2:0]  ROB_tail;
    logic        ROB_stall;
    logic        ROB_cmp0, ROB_cmp1;
    logic [2:0]  ROB_cmp0_id, ROB_cmp1_id;
    logic [31:0] ROB_cmp0_value, ROB_cmp1_value;
    logic [4:0]  ROB_dAddr1, ROB_dAddr2;
    logic        ROB_dependency1, ROB_dependency2;
    logic        ROB_resolved1, ROB_resolved2;
    logic [31:0] ROB_dValue1, ROB_dValue2;
    logic [4:0]  ROB_Wat;
    logic [31:0] ROB_Wvalue;
    logic        ROB_We;
    logic        ROB_flush;

    reorder_buffer #(.REG_ADDRESS_SIZE(5), .REG_SIZE(32), .ID_SIZE(3)) dut (
        .clk(clk), .reset(reset),
        .ROB_alloc(ROB_alloc), .ROB_alloc_dest(ROB_alloc_dest), .ROB_alloc_w(ROB_alloc_w),
        .ROB_tail(ROB_tail), .ROB_stall(ROB_stall),
        .ROB_cmp0(ROB_cmp0), .ROB_cmp0_id(ROB_cmp0_id), .ROB_cmp0_value(ROB_cmp0_value),
        .ROB_cmp1(ROB_cmp1), .ROB_cmp1_id(ROB_cmp1_id), .ROB_cmp1_value(ROB_cmp1_value),
        .ROB_dAddr1(ROB_dAddr1), .ROB_dAddr2(ROB_dAddr2),
        .ROB_dependency1(ROB_dependency1), .ROB_dependency2(ROB_dependency2),
        .ROB_resolved1(ROB_resolved1), .ROB_resolved2(ROB_resolved2),
        .ROB_dValue1(ROB_dValue1), .ROB_dValue2(ROB_dValue2),
        .ROB_Wat(ROB_Wat), .ROB_Wvalue(ROB_Wvalue), .ROB_We(ROB_We),
        .ROB_flush(ROB_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        bit         w;
        bit [4:0]   dest;
        bit         done;
        bit [31:0]  value;
    } ent_t;

    ent_t rob[$];
    int   head_id = 0;
    int   compared = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ROB_alloc = 0; ROB_alloc_dest = 0; ROB_alloc_w = 0;
        ROB_cmp0 = 0; ROB_cmp0_id = 0; ROB_cmp0_value = 0;
        ROB_cmp1 = 0; ROB_cmp1_id = 0; ROB_cmp1_value = 0;
        ROB_dAddr1 = 0; ROB_dAddr2 = 0; ROB_flush = 0;
    endtask

    // Youngest in-flight writer of register a, as seen by decode this cycle.
    function automatic void exp_lookup(input bit [4:0] a, output bit dep, output bit res,
                                       output bit [31:0] val);
        dep = 0; res = 0; val = 0;
        if (a != 0) begin
            for (int i = rob.size() - 1; i >= 0; i--) begin
                if (rob[i].w && rob[i].dest == a) begin
                    dep = 1; res = rob[i].done; val = rob[i].value;
`ifdef ROB_FORWARD_EN
                    if (ROB_cmp0 && ROB_cmp0_id == 3'(rob[i].id)) begin
                        res = 1; val = ROB_cmp0_value;
                    end else if (ROB_cmp1 && ROB_cmp1_id == 3'(rob[i].id)) begin
                        res = 1; val = ROB_cmp1_value;
                    end
`endif
                    break;
                end
            end
        end
    endfunction

    task automatic complete(input bit [2:0] id, input bit [31:0] v);
        foreach (rob[i])
            if (rob[i].id == int'(id)) begin
                rob[i].done = 1; rob[i].value = v;
            end
    endtask

    task automatic model_update(input bit commit);
        bit full;
        full = (rob.size() == DEPTH);
        if (ROB_flush) begin
            if (commit) head_id = (head_id + 1) % DEPTH;
            rob.delete();
        end else begin
            if (ROB_cmp1) complete(ROB_cmp1_id, ROB_cmp1_value);
            if (ROB_cmp0) complete(ROB_cmp0_id, ROB_cmp0_value);
            if (commit) begin
                void'(rob.pop_front());
                head_id = (head_id + 1) % DEPTH;
            end
            if (ROB_alloc && !full)
                rob.push_back('{(head_id + rob.size()) % DEPTH, ROB_alloc_w, ROB_alloc_dest, 1'b0, 32'h0});
        end
    endtask

    // Check all outputs against the model, then advance one clock with the current inputs.
    task automatic cycle();
        bit commit, exp_we, d, r;
        bit [31:0] v;
        #1;
        chk("stall", ROB_stall, rob.size() == DEPTH);
        chk("tail", ROB_tail, (head_id + rob.size()) % DEPTH);
        commit = (rob.size() > 0) && rob[0].done;
        exp_we = commit && rob[0].w && rob[0].dest != 0;
        chk("we", ROB_We, exp_we);
        if (exp_we) begin
            chk("wat", ROB_Wat, rob[0].dest);
            chk("wvalue", ROB_Wvalue, rob[0].value);
        end
        exp_lookup(ROB_dAddr1, d, r, v);
        chk("dep1", ROB_dependency1, d);
        chk("res1", ROB_resolved1, r);
        chk("val1", ROB_dValue1, v);
        exp_lookup(ROB_dAddr2, d, r, v);
        chk("dep2", ROB_dependency2, d);
        chk("res2", ROB_resolved2, r);
        chk("val2", ROB_dValue2, v);
        @(posedge clk);
        model_update(commit);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        ROB_dAddr1 = 5'd1;
        #1;
        chk("rst_stall", ROB_stall, 0);
        chk("rst_we", ROB_We, 0);
        chk("rst_tail", ROB_tail, 0);
        chk("rst_dep1", ROB_dependency1, 0);
        repeat (2) @(negedge clk);
        rob.delete();
        head_id = 0;
        reset = 1;
        idle();
    endtask

    initial begin
        idle();
        reset = 0;
        @(negedge clk);
        do_reset();

        // Fill to capacity, then one extra allocation that must be dropped
        for (int i = 1; i <= 8; i++) begin
            idle(); ROB_alloc = 1; ROB_alloc_dest = 5'(i); ROB_alloc_w = 1;
            cycle();
        end
        idle(); #1;
        chk("full_stall", ROB_stall, 1);
        chk("full_tail", ROB_tail, 0);
        ROB_alloc = 1; ROB_alloc_dest = 5'd9; ROB_alloc_w = 1;
        cycle();
        idle(); #1;
        chk("ovf_tail", ROB_tail, 0);
        chk("ovf_stall", ROB_stall, 1);
        cycle();

        // Completion in cycle N commits in cycle N+1
        do_reset();
        ROB_alloc = 1; ROB_alloc_dest = 5'd3; ROB_alloc_w = 1;
        cycle();
        idle(); ROB_cmp0 = 1; ROB_cmp0_id = 0; ROB_cmp0_value = 32'h55;
        cycle();
        idle(); #1;
        chk("c2c_we", ROB_We, 1);
        chk("c2c_wat", ROB_Wat, 3);
        chk("c2c_wvalue", ROB_Wvalue, 32'h55);
        cycle();

        // Youngest producer selection and forwarding behaviour
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle(); ROB_alloc = 1; ROB_alloc_dest = 5'd5; ROB_alloc_w = 1;
            cycle();
        end
        idle(); ROB_cmp0 = 1; ROB_cmp0_id = 0; ROB_cmp0_value = 32'h11; ROB_dAddr1 = 5'd5;
        #1;
        chk("young_dep", ROB_dependency1, 1);
        chk("young_res", ROB_resolved1, 0);
        cycle();
        idle(); ROB_cmp1 = 1; ROB_cmp1_id = 1; ROB_cmp1_value = 32'hA; ROB_dAddr1 = 5'd5;
        #1;
`ifdef ROB_FORWARD_EN
        chk("fwd_res", ROB_resolved1, 1);
        chk("fwd_val", ROB_dValue1, 32'hA);
`else
        chk("nofwd_res", ROB_resolved1, 0);
`endif
        cycle();
        idle(); ROB_dAddr1 = 5'd5;
        #1;
        chk("late_res", ROB_resolved1, 1);
        chk("late_val", ROB_dValue1, 32'hA);
        cycle();

        // Flush with a committable head
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            idle(); ROB_alloc = 1; ROB_alloc_dest = 5'(i); ROB_alloc_w = 1;
            cycle();
        end
        idle(); ROB_cmp0 = 1; ROB_cmp0_id = 0; ROB_cmp0_value = 32'h77;
        cycle();
        idle(); ROB_flush = 1; ROB_dAddr1 = 5'd2;
        #1;
        chk("flush_we", ROB_We, 1);
        cycle();
        idle(); ROB_dAddr1 = 5'd2; ROB_dAddr2 = 5'd4;
        #1;
        chk("flush_tail", ROB_tail, 1);
        chk("flush_stall", ROB_stall, 0);
        chk("flush_dep1", ROB_dependency1, 0);
        chk("flush_dep2", ROB_dependency2, 0);
        cycle();

        // Random traffic, with an asynchronous reset in the middle
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            if (n == 1500) begin
                #2;
                reset = 0;
                #1;
                chk("mid_rst_tail", ROB_tail, 0);
                chk("mid_rst_stall", ROB_stall, 0);
                chk("mid_rst_we", ROB_We, 0);
                @(negedge clk);
                rob.delete();
                head_id = 0;
                reset = 1;
            end
            ROB_alloc      = ($urandom_range(0, 9) < 6);
            ROB_alloc_dest = 5'($urandom_range(0, 7));
            ROB_alloc_w    = ($urandom_range(0, 7) != 0);
            ROB_cmp0       = ($urandom_range(0, 2) == 0);
            ROB_cmp1       = ($urandom_range(0, 2) == 0);
            ROB_cmp0_id    = (rob.size() > 0 && $urandom_range(0, 3) != 0)
                             ? 3'(rob[$urandom_range(0, rob.size() - 1)].id) : 3'($urandom_range(0, 7));
            ROB_cmp1_id    = (rob.size() > 0 && $urandom_range(0, 3) != 0)
                             ? 3'(rob[$urandom_range(0, rob.size() - 1)].id) : 3'($urandom_range(0, 7));
            ROB_cmp0_value = $urandom;
            ROB_cmp1_value = $urandom;
            ROB_dAddr1     = 5'($urandom_range(0, 7));
            ROB_dAddr2     = 5'($urandom_range(0, 7));
            ROB_flush      = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
